// File: rtl/pkt_wr_sched_pkg.sv
// Shared types and constants for the packet write scheduler.
package pkt_wr_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        ISSUE,
        WAIT,
        COMMIT
    } state_t;

    // Packet descriptor: byte offsets, end is exclusive.
    typedef struct packed {
        logic [31:0] pkt_begin;
        logic [31:0] pkt_end;
    } desc_t;

    // A packet is unusable if empty, not whole words, or larger than the limit.
    function automatic logic desc_malformed(input logic [31:0] len,
                                            input logic [31:0] max_bytes);
        return (len == '0) || (len[1:0] != 2'b00) || (len > max_bytes);
    endfunction

endpackage

// File: rtl/pkt_wr_sched_desc_fifo.sv
// First-word-fall-through descriptor queue; a push into a full queue is
// accepted when a pop happens in the same cycle.
module desc_fifo
    import pkt_wr_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  desc_t wr_data,
    input  logic  pop,
    output desc_t rd_data,
    output logic  full,
    output logic  empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW:0]   cnt_t;
    typedef logic [AW-1:0] idx_t;

    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam idx_t IDX_ONE  = idx_t'(1);

    desc_t mem_q [DEPTH];
    idx_t  wr_idx_q;
    idx_t  rd_idx_q;
    cnt_t  cnt_q;
    logic  push_ok;
    logic  pop_ok;

    assign full    = (cnt_q == CNT_FULL);
    assign empty   = (cnt_q == '0);
    assign rd_data = mem_q[rd_idx_q];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Storage array; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_idx_q] <= wr_data;
        end
    end

    // Read/write indices and occupancy count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_idx_q <= wr_idx_q + IDX_ONE;
            end
            if (pop_ok) begin
                rd_idx_q <= rd_idx_q + IDX_ONE;
            end
            if (push_ok && !pop_ok) begin
                cnt_q <= cnt_q + CNT_ONE;
            end else if (pop_ok && !push_ok) begin
                cnt_q <= cnt_q - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/pkt_wr_sched.sv
// Schedules captured-packet writes into a host ring buffer: queues
// descriptors, waits for ring space, issues one wr_ctrl burst per packet
// and advances the producer pointer with wrap.
module pkt_wr_sched
    import pkt_wr_pkg::*;
#(
    parameter int unsigned DESC_DEPTH = 8,
    parameter logic [31:0] RING_BASE  = 32'h0,
    parameter logic [31:0] RING_SIZE  = 32'h100000,
    parameter int unsigned MAX_WORDS  = 256,
    parameter int unsigned TIMEOUT    = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        desc_valid,
    input  logic [31:0] desc_begin,
    input  logic [31:0] desc_end,
    output logic        desc_ready,
    input  logic [31:0] host_rd_ptr,
    output logic        wc_start,
    output logic [31:0] wc_pkt_begin,
    output logic [31:0] wc_pkt_end,
    output logic [31:0] wc_wr_addr,
    input  logic        wc_rdy,
    output logic [31:0] wr_ptr,
    output logic [31:0] pkt_count,
    output logic [15:0] drop_count,
    output logic        timeout_err,
    output logic        irq
);

    localparam logic [31:0] MAX_BYTES = 32'(MAX_WORDS * WORD_BYTES);
    localparam logic [31:0] RESERVE   = 32'(WORD_BYTES);
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT - 1);

    state_t      state_q, state_d;
    desc_t       cur_q, cur_d;
    logic [31:0] len_q, len_d;
    logic [31:0] wr_ptr_q, wr_ptr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] drop_q, drop_d;
    logic        tmo_q, tmo_d;
    logic [31:0] wcnt_q, wcnt_d;
    logic        rdy_prev_q;

    desc_t       head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic        fifo_push;

    logic [31:0] used;
    logic [31:0] free_bytes;
    logic [32:0] end_sum;
    logic        wrap;
    logic [32:0] need;
    logic        bad_len;
    logic [31:0] commit_ptr;

    assign desc_ready = !fifo_full;
    assign fifo_push  = desc_valid && !fifo_full;

    desc_fifo #(
        .DEPTH (DESC_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .wr_data ('{pkt_begin: desc_begin, pkt_end: desc_end}),
        .pop     (fifo_pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Ring occupancy, wrap decision and space requirement for the loaded packet.
    always_comb begin
        used       = (wr_ptr_q >= host_rd_ptr) ? (wr_ptr_q - host_rd_ptr)
                                               : (wr_ptr_q + RING_SIZE - host_rd_ptr);
        free_bytes = RING_SIZE - RESERVE - used;
        end_sum    = {1'b0, wr_ptr_q} + {1'b0, len_q};
        wrap       = (end_sum > {1'b0, RING_SIZE});
        need       = wrap ? ({1'b0, len_q} + {1'b0, RING_SIZE - wr_ptr_q})
                          : {1'b0, len_q};
        bad_len    = desc_malformed(len_q, MAX_BYTES);
        commit_ptr = (end_sum[31:0] == RING_SIZE) ? '0 : end_sum[31:0];
    end

    // Next-state logic, register next values and single-cycle pulses.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        len_d     = len_q;
        wr_ptr_d  = wr_ptr_q;
        addr_d    = addr_q;
        pkt_cnt_d = pkt_cnt_q;
        drop_d    = drop_q;
        tmo_d     = tmo_q;
        wcnt_d    = wcnt_q;
        fifo_pop  = 1'b0;
        wc_start  = 1'b0;
        irq       = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                fifo_pop = 1'b1;
                cur_d    = head;
                len_d    = head.pkt_end - head.pkt_begin;
                state_d  = CHECK;
            end
            CHECK: begin
                if (bad_len) begin
                    if (drop_q != '1) begin
                        drop_d = drop_q + 16'd1;
                    end
                    state_d = IDLE;
                end else if (need > {1'b0, free_bytes}) begin
                    state_d = CHECK;
                end else begin
                    if (wrap) begin
                        wr_ptr_d = '0;
                        addr_d   = RING_BASE;
                    end else begin
                        addr_d   = RING_BASE + wr_ptr_q;
                    end
                    wcnt_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wc_start = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                // Only a fresh rising edge counts; a level already high at issue is stale.
                if (wc_rdy && !rdy_prev_q) begin
                    state_d = COMMIT;
                end else if (wcnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + 32'd1;
                end
            end
            COMMIT: begin
                irq       = 1'b1;
                wr_ptr_d  = commit_ptr;
                pkt_cnt_d = pkt_cnt_q + 32'd1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            len_q      <= '0;
            wr_ptr_q   <= '0;
            addr_q     <= '0;
            pkt_cnt_q  <= '0;
            drop_q     <= '0;
            tmo_q      <= 1'b0;
            wcnt_q     <= '0;
            rdy_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            len_q      <= len_d;
            wr_ptr_q   <= wr_ptr_d;
            addr_q     <= addr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_q     <= drop_d;
            tmo_q      <= tmo_d;
            wcnt_q     <= wcnt_d;
            rdy_prev_q <= wc_rdy;
        end
    end

    assign wc_pkt_begin = cur_q.pkt_begin;
    assign wc_pkt_end   = cur_q.pkt_end;
    assign wc_wr_addr   = addr_q;
    assign wr_ptr       = wr_ptr_q;
    assign pkt_count    = pkt_cnt_q;
    assign drop_count   = drop_q;
    assign timeout_err  = tmo_q;

endmodule

// File: tb/tb_pkt_wr_sched.sv
// Directed self-checking bench for pkt_wr_sched using a small ring.
module tb_pkt_wr_sched;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] RSIZE = 32'h200;
    localparam int unsigned MAXW  = 128;
    localparam int unsigned TMO   = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        desc_valid;
    logic [31:0] desc_begin;
    logic [31:0] desc_end;
    logic        desc_ready;
    logic [31:0] host_rd_ptr;
    logic        wc_start;
    logic [31:0] wc_pkt_begin;
    logic [31:0] wc_pkt_end;
    logic [31:0] wc_wr_addr;
    logic        wc_rdy;
    logic [31:0] wr_ptr;
    logic [31:0] pkt_count;
    logic [15:0] drop_count;
    logic        timeout_err;
    logic        irq;

    int vectors     = 0;
    int miscompares = 0;
    int start_cnt   = 0;
    int snap;

    always #5 clk = ~clk;

    pkt_wr_sched #(
        .DESC_DEPTH (8),
        .RING_BASE  (BASE),
        .RING_SIZE  (RSIZE),
        .MAX_WORDS  (MAXW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .desc_valid   (desc_valid),
        .desc_begin   (desc_begin),
        .desc_end     (desc_end),
        .desc_ready   (desc_ready),
        .host_rd_ptr  (host_rd_ptr),
        .wc_start     (wc_start),
        .wc_pkt_begin (wc_pkt_begin),
        .wc_pkt_end   (wc_pkt_end),
        .wc_wr_addr   (wc_wr_addr),
        .wc_rdy       (wc_rdy),
        .wr_ptr       (wr_ptr),
        .pkt_count    (pkt_count),
        .drop_count   (drop_count),
        .timeout_err  (timeout_err),
        .irq          (irq)
    );

    // Count every start pulse seen by the bench.
    always @(negedge clk) begin
        if (wc_start === 1'b1) start_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] b, input logic [31:0] e);
        @(negedge clk);
        desc_valid = 1'b1;
        desc_begin = b;
        desc_end   = e;
        @(negedge clk);
        desc_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (wc_start !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, wc_start}, 32'd1);
    endtask

    // From the ISSUE cycle: raise wc_rdy in WAIT, expect irq, then the new pointer.
    task automatic complete(input logic [31:0] exp_wr, input string tag);
        @(negedge clk);
        wc_rdy = 1'b1;
        @(negedge clk);
        chk({tag, "_irq"}, {31'd0, irq}, 32'd1);
        wc_rdy = 1'b0;
        @(negedge clk);
        chk({tag, "_wrptr"}, wr_ptr, exp_wr);
    endtask

    task automatic run_pkt(input logic [31:0] b, input logic [31:0] e,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wr,
                           input string tag);
        push(b, e);
        wait_start({tag, "_start"});
        chk({tag, "_addr"}, wc_wr_addr, exp_addr);
        complete(exp_wr, tag);
    endtask

    initial begin
        reset       = 1'b0;
        enable      = 1'b0;
        desc_valid  = 1'b0;
        desc_begin  = '0;
        desc_end    = '0;
        host_rd_ptr = '0;
        wc_rdy      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, desc_ready}, 32'd1);
        chk("rst_wrptr", wr_ptr, 32'd0);
        chk("rst_pktcnt", pkt_count, 32'd0);
        chk("rst_drop", {16'd0, drop_count}, 32'd0);
        chk("rst_tmo_irq_start", {29'd0, timeout_err, irq, wc_start}, 32'd0);
        reset  = 1'b1;
        enable = 1'b1;
        @(negedge clk);

        // Single packet 0x0..0x40: start exactly 3 cycles after the push.
        push(32'h0, 32'h40);
        @(negedge clk);
        @(negedge clk);
        chk("lat_not_yet", {31'd0, wc_start}, 32'd0);
        @(negedge clk);
        chk("lat_start", {31'd0, wc_start}, 32'd1);
        chk("p1_addr", wc_wr_addr, BASE);
        chk("p1_begin", wc_pkt_begin, 32'h0);
        chk("p1_end", wc_pkt_end, 32'h40);
        complete(32'h40, "p1");
        chk("p1_once", start_cnt, 32'd1);
        chk("p1_count", pkt_count, 32'd1);

        // Walk the producer up to RING_SIZE-0x20.
        host_rd_ptr = 32'h40;
        run_pkt(32'h1000, 32'h1100, BASE + 32'h40, 32'h140, "p2");
        host_rd_ptr = 32'h140;
        run_pkt(32'h2000, 32'h20A0, BASE + 32'h140, 32'h1E0, "p3");

        // Packet would straddle the ring end: placed at offset 0.
        host_rd_ptr = 32'h100;
        run_pkt(32'h3000, 32'h3040, BASE, 32'h40, "wrap");

        // Packet ending exactly at ring end: no relocation, pointer wraps to 0.
        host_rd_ptr = 32'h40;
        run_pkt(32'h4000, 32'h41C0, BASE + 32'h40, 32'h0, "fill");

        // used = RING_SIZE-0x10: stall until the host frees space.
        host_rd_ptr = 32'h10;
        snap = start_cnt;
        push(32'h5000, 32'h5040);
        repeat (20) @(negedge clk);
        chk("stall_no_start", start_cnt - snap, 32'd0);
        host_rd_ptr = 32'h110;
        wait_start("stall_release");
        chk("stall_addr", wc_wr_addr, BASE);
        complete(32'h40, "stall");
        chk("pktcnt6", pkt_count, 32'd6);

        // Malformed descriptors are dropped without a burst.
        host_rd_ptr = 32'h40;
        snap = start_cnt;
        push(32'h100, 32'h100);
        push(32'h100, 32'h103);
        push(32'h100, 32'h100 + MAXW * 4 + 4);
        repeat (20) @(negedge clk);
        chk("drop_no_start", start_cnt - snap, 32'd0);
        chk("drop_count", {16'd0, drop_count}, 32'd3);
        chk("drop_wrptr", wr_ptr, 32'h40);

        // wc_rdy stuck high: no valid completion edge.
        wc_rdy = 1'b1;
        push(32'h6000, 32'h6040);
        wait_start("tmo_start");
        repeat (TMO) @(negedge clk);
        chk("tmo_not_yet", {31'd0, timeout_err}, 32'd0);
        @(negedge clk);
        chk("tmo_err", {31'd0, timeout_err}, 32'd1);
        chk("tmo_wrptr", wr_ptr, 32'h40);
        chk("tmo_pktcnt", pkt_count, 32'd6);
        wc_rdy = 1'b0;

        // Fill the queue with fetching disabled.
        enable = 1'b0;
        for (int i = 0; i < 9; i++) begin
            push(32'h7000, 32'h7040);
            if (i == 6) chk("q7_ready", {31'd0, desc_ready}, 32'd1);
            if (i == 7) chk("q8_full", {31'd0, desc_ready}, 32'd0);
        end
        chk("q9_full", {31'd0, desc_ready}, 32'd0);

        // Release one packet, then reset while waiting on wr_ctrl.
        enable = 1'b1;
        wait_start("q_start");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_wrptr", wr_ptr, 32'd0);
        chk("mid_rst_pktcnt", pkt_count, 32'd0);
        chk("mid_rst_drop", {16'd0, drop_count}, 32'd0);
        chk("mid_rst_tmo", {31'd0, timeout_err}, 32'd0);
        chk("mid_rst_ready", {31'd0, desc_ready}, 32'd1);
        chk("mid_rst_addr", wc_wr_addr, 32'd0);
        reset = 1'b1;
        snap  = start_cnt;
        repeat (12) @(negedge clk);
        chk("flushed_no_start", start_cnt - snap, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
